serial_frame_deser: RTL and testbench
=====================================

Name: serial_frame_deser

Overview:
- Upstream feeder for the team's parallel holding register.
- Deserializes an async-style serial frame: 1 start bit (0), WIDTH data bits LSB-first, 1 stop bit (1).
- Bits are sampled only on an externally supplied sample strobe `tick`.
- On a valid frame, presents the word on `dout` and pulses `load` for one clock; `load` drives the holding register's enable, and `dout` drives its data input.

Parameters:
- WIDTH, 8, number of data bits per frame and width of `dout`.

Ports:
- clk  input  1  rising-edge clock.
- rst_  input  1  reset, asynchronous, active-low.
- tick  input  1  sample strobe; one clk wide, one per bit period.
- sin  input  1  serial input line; idle level 1.
- dout  output  WIDTH  last correctly framed word.
- load  output  1  one-clk pulse when `dout` is updated.
- frame_err  output  1  one-clk pulse on stop-bit error.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst_ = 0, asynchronous): state = IDLE; shift register = 0; bit count = 0; dout = 0; load = 0; frame_err = 0; busy = 0. Reset asserted mid-frame aborts the frame; no load and no frame_err pulse are produced.
- All state changes happen only on clk edges where tick = 1. With tick = 0, state, count and shift register hold; load and frame_err return to 0.
- IDLE: tick & sin = 0 -> DATA; clear bit count. Otherwise remain in IDLE.
- DATA: on tick, shift right with sin entering the MSB, so the first data bit lands in bit 0 after WIDTH shifts. Increment the count. When the count reaches WIDTH-1 on that tick -> STOP.
- STOP, on tick:
  - sin = 1: dout <= shift register; load <= 1 for exactly that one cycle; -> IDLE.
  - sin = 0: frame_err <= 1 for one cycle; dout unchanged; load stays 0; -> BREAK.
- BREAK: on tick with sin = 1 -> IDLE. Otherwise remain. This prevents a held-low line from re-triggering starts.
- Latency: load and the new dout appear at the clk edge of the stop-bit tick, i.e. registered and visible in the following cycle. dout holds its value until the next load.
- Back-to-back frames: a start bit sampled on the tick immediately after the stop tick is accepted, with no dead time.
- busy = 1 in DATA, STOP and BREAK; 0 in IDLE.
- load and frame_err are never high in the same cycle.
- Widths: bit counter is $clog2(WIDTH) bits, with no wrap beyond WIDTH-1.
- All outputs come directly from registers; no combinational path from sin or tick to any output.

Decomposition:
- Package `serial_frame_pkg`: typedef enum logic [1:0] {IDLE, DATA, STOP, BREAK} deser_state_t.
- No sub-module; the counter and shift register stay inline.

Test Plan (WIDTH = 8, tick every 4 clks unless stated):
- Frame 0xA5 (sin: 0, 1,0,1,0,0,1,0,1, 1) -> single load pulse at stop tick; dout = 0xA5; frame_err never high; busy high from the start tick until the stop tick.
- Frames 0x3C then 0xFF back-to-back, no idle bits -> two load pulses exactly 10 ticks apart; dout = 0x3C then 0xFF.
- Frame 0x55 with stop bit = 0, then line held low for 3 ticks, then high, then frame 0x81 -> one frame_err pulse; dout stays at its prior value; no start during the low period; then load with dout = 0x81.
- rst_ pulsed low for 2 clks after the 4th data bit of frame 0x12, then frame 0x34 -> no load for 0x12; all outputs 0 during reset; load with dout = 0x34.
- tick held low for 20 clks in mid-frame 0xC3 -> state frozen during the gap; frame completes with dout = 0xC3.
- Glitch: sin = 0 between ticks but 1 at every tick -> remains in IDLE, busy = 0, no load.

Source files
------------

// File: rtl/serial_frame_deser_pkg.sv
// Shared types for the serial frame deserializer.
package serial_frame_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      STOP  = 2'd2,
      BREAK = 2'd3
   } deser_state_t;

   // Bit-counter width; a single-bit frame still needs a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_frame_deser_if.sv
// Serial line and parallel-word side of the deserializer.
interface serial_frame_deser_if #(
   parameter int unsigned WIDTH = 8
);
   logic             tick;
   logic             sin;
   logic [WIDTH-1:0] dout;
   logic             load;
   logic             frame_err;
   logic             busy;

   modport master (output tick, sin, input dout, load, frame_err, busy);
   modport slave  (input tick, sin, output dout, load, frame_err, busy);
endinterface

// File: rtl/serial_frame_deser.sv
// Start/data/stop serial frame deserializer sampled on an external tick.
module serial_frame_deser
   import serial_frame_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input logic                 clk,
   input logic                 rst_,
   serial_frame_deser_if.slave bus
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   deser_state_t     state;
   deser_state_t     nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sh;

   // Next-state decode; only a tick can move the machine.
   always_comb begin
      nxt = state;
      if (bus.tick) begin
         case (state)
            IDLE:    if (!bus.sin) nxt = DATA;
            DATA:    if (cnt == LAST) nxt = STOP;
            STOP:    nxt = bus.sin ? IDLE : BREAK;
            BREAK:   if (bus.sin) nxt = IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   // State, counter, shift register and registered outputs.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state         <= IDLE;
         cnt           <= '0;
         sh            <= '0;
         bus.dout      <= '0;
         bus.load      <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         bus.load      <= 1'b0;
         bus.frame_err <= 1'b0;
         state         <= nxt;
         // busy is registered from the next state so it stays a pure flop output
         bus.busy      <= (nxt != IDLE);
         if (bus.tick) begin
            case (state)
               IDLE: begin
                  if (!bus.sin) cnt <= '0;
               end
               DATA: begin
                  sh <= (sh >> 1) | (WIDTH'(bus.sin) << (WIDTH - 1));
                  if (cnt != LAST) cnt <= cnt + CW'(1);
               end
               STOP: begin
                  if (bus.sin) begin
                     bus.dout <= sh;
                     bus.load <= 1'b1;
                  end else begin
                     bus.frame_err <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_deser.sv
// Randomized and directed bench for serial_frame_deser against a frame-level model.
module tb_serial_frame_deser;

   localparam int unsigned WIDTH = 8;

   logic clk = 1'b0;
   logic rst_ = 1'b0;

   serial_frame_deser_if #(.WIDTH(WIDTH)) bus ();

   serial_frame_deser #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit cmp_on = 1'b0;

   // Frame-level model: hunting for a start, collecting WIDTH+1 samples, or waiting for line high.
   int             phase;
   bit             samples[$];
   logic [WIDTH-1:0] exp_dout;
   bit             exp_load, exp_err, exp_busy;
   int             tick_cnt;
   int             load_cnt, err_cnt, last_load_tick, prev_load_tick;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      phase    = 0;
      samples.delete();
      exp_dout = '0;
      exp_load = 0;
      exp_err  = 0;
      exp_busy = 0;
   endtask

   task automatic model_edge(input bit t, input bit s);
      logic [WIDTH-1:0] w;
      exp_load = 0;
      exp_err  = 0;
      if (t) begin
         tick_cnt++;
         if (phase == 0) begin
            if (!s) begin
               phase = 1;
               samples.delete();
            end
         end else if (phase == 1) begin
            samples.push_back(s);
            if (samples.size() == WIDTH + 1) begin
               if (s) begin
                  w = '0;
                  for (int i = 0; i < int'(WIDTH); i++) w = w + (WIDTH'(samples[i]) << i);
                  exp_dout = w;
                  exp_load = 1;
                  phase = 0;
               end else begin
                  exp_err = 1;
                  phase = 2;
               end
            end
         end else begin
            if (s) phase = 0;
         end
      end
      exp_busy = (phase != 0);
   endtask

   task automatic clk_step(input bit t, input bit s);
      bus.tick = t;
      bus.sin  = s;
      @(posedge clk);
      if (rst_) model_edge(t, s);
      #1;
   endtask

   task automatic send_bit(input bit b, input int period);
      clk_step(1'b1, b);
      for (int i = 1; i < period; i++) clk_step(1'b0, b);
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] w, input bit stop_b, input int period);
      send_bit(1'b0, period);
      for (int i = 0; i < int'(WIDTH); i++) send_bit(w[i], period);
      send_bit(stop_b, period);
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_on) begin
         check("dout", bus.dout, exp_dout);
         check("load", bus.load, exp_load);
         check("frame_err", bus.frame_err, exp_err);
         check("busy", bus.busy, exp_busy);
         check("load_err_excl", bus.load & bus.frame_err, 0);
         if (bus.load) begin
            load_cnt++;
            prev_load_tick = last_load_tick;
            last_load_tick = tick_cnt;
         end
         if (bus.frame_err) err_cnt++;
      end
   end

   initial begin
      logic [WIDTH-1:0] w;
      int p, loads0, errs0;
      tick_cnt = 0; load_cnt = 0; err_cnt = 0; last_load_tick = 0; prev_load_tick = 0;
      model_reset();
      bus.tick = 1'b0;
      bus.sin  = 1'b1;
      rst_ = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dout", bus.dout, 0);
      check("rst_load", bus.load, 0);
      check("rst_err", bus.frame_err, 0);
      check("rst_busy", bus.busy, 0);
      rst_ = 1'b1;
      cmp_on = 1'b1;
      repeat (3) send_bit(1'b1, 4);

      // Single frame 0xA5
      send_frame(8'hA5, 1'b1, 4);
      check("a5_dout", bus.dout, 8'hA5);
      check("a5_loads", load_cnt, 1);
      check("a5_errs", err_cnt, 0);
      send_bit(1'b1, 4);

      // Back-to-back 0x3C, 0xFF
      send_frame(8'h3C, 1'b1, 4);
      check("b2b_first", bus.dout, 8'h3C);
      send_frame(8'hFF, 1'b1, 4);
      check("b2b_second", bus.dout, 8'hFF);
      check("b2b_loads", load_cnt, 3);
      check("b2b_spacing", last_load_tick - prev_load_tick, 10);

      // Bad stop bit, held-low line, then a good frame
      send_bit(1'b1, 4);
      send_frame(8'h55, 1'b0, 4);
      check("brk_err", err_cnt, 1);
      check("brk_dout", bus.dout, 8'hFF);
      repeat (3) send_bit(1'b0, 4);
      check("brk_busy", bus.busy, 1);
      check("brk_noload", load_cnt, 3);
      send_bit(1'b1, 4);
      check("brk_idle", bus.busy, 0);
      send_frame(8'h81, 1'b1, 4);
      check("brk_recover", bus.dout, 8'h81);

      // Reset in the middle of frame 0x12
      send_bit(1'b1, 4);
      w = 8'h12;
      send_bit(1'b0, 4);
      for (int i = 0; i < 4; i++) send_bit(w[i], 4);
      rst_ = 1'b0;
      model_reset();
      #1;
      check("mid_rst_dout", bus.dout, 0);
      check("mid_rst_busy", bus.busy, 0);
      clk_step(1'b0, 1'b1);
      clk_step(1'b0, 1'b1);
      rst_ = 1'b1;
      loads0 = load_cnt;
      repeat (2) send_bit(1'b1, 4);
      check("rst_noload", load_cnt, loads0);
      send_frame(8'h34, 1'b1, 4);
      check("rst_recover", bus.dout, 8'h34);
      check("rst_loads", load_cnt, loads0 + 1);

      // Tick gap mid-frame 0xC3
      send_bit(1'b1, 4);
      w = 8'hC3;
      send_bit(1'b0, 4);
      for (int i = 0; i < 4; i++) send_bit(w[i], 4);
      repeat (20) clk_step(1'b0, w[3]);
      check("gap_busy", bus.busy, 1);
      for (int i = 4; i < int'(WIDTH); i++) send_bit(w[i], 4);
      send_bit(1'b1, 4);
      check("gap_dout", bus.dout, 8'hC3);

      // Glitches low between ticks only
      loads0 = load_cnt;
      repeat (6) begin
         clk_step(1'b1, 1'b1);
         clk_step(1'b0, 1'b0);
         clk_step(1'b0, 1'b0);
         clk_step(1'b0, 1'b0);
      end
      check("glitch_busy", bus.busy, 0);
      check("glitch_noload", load_cnt, loads0);

      // Randomized frames, stop bits, gaps and tick periods
      for (int n = 0; n < 40; n++) begin
         p = $urandom_range(1, 5);
         w = WIDTH'($urandom);
         errs0 = ($urandom_range(0, 7) == 0) ? 1 : 0;
         send_frame(w, errs0 == 0, p);
         if (errs0 != 0) repeat ($urandom_range(0, 3)) send_bit(1'b0, p);
         repeat ($urandom_range(0, 2)) send_bit(1'b1, p);
         if (errs0 != 0) send_bit(1'b1, p);
      end
      repeat (4) clk_step(1'b0, 1'b1);

      cmp_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
